iq_diff_slicer: RTL and testbench

Downstream of the IQ analysis stage. It takes the averaged differential vectors DI/DQ on each output strobe and makes a differential-phase bit decision from the dot product with the previous vector. It hunts for a 16-bit sync word, then assembles the following frame into bytes. Bytes go out through a small FIFO with a valid/ready handshake toward the packet/CPU interface.

---
 rtl/iq_diff_slicer_pkg.sv | 29 ++
 rtl/iq_diff_slicer_if.sv | 16 +
 rtl/iq_diff_slicer_fifo.sv | 59 +++++
 rtl/iq_diff_slicer.sv | 200 ++++++++++++++++++++
 tb/tb_iq_diff_slicer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_diff_slicer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : iq_demod_pkg                                              |
// | Shared types and widths for the differential IQ slicer.            |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package iq_demod_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [15:0] c_sync_word_default = 16'hA5C3;
    localparam int          c_data_width        = 16;
    localparam int          c_vec_width         = c_data_width + 8;
    localparam int          c_v_w               = 16;
    localparam int          c_p_w               = 32;
    localparam int          c_dot_w             = 33;

    // Magnitude of a dot product; the most negative value maps to 2^32,
    // which is still correct when read as unsigned.
    function automatic logic [c_dot_w-1:0] abs_dot(input logic signed [c_dot_w-1:0] d);
        return d[c_dot_w-1] ? -d : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_diff_slicer_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : iq_diff_slicer_if                                         |
// | Byte stream valid/ready handshake toward the packet interface.     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface iq_diff_slicer_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, output byte_valid, input  byte_ready);
    modport slave  (input  byte_out, input  byte_valid, output byte_ready);
endinterface
`default_nettype wire

// File: rtl/iq_diff_slicer_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : iq_byte_fifo                                              |
// | First-word-fall-through FIFO; head holds last value when empty.    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module iq_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr;
    logic [c_aw:0]    r_rd;
    logic [WIDTH-1:0] r_last;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_wr == r_rd);
    assign full      = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = empty ? r_last : r_mem[r_rd[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[c_aw-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_last <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_last <= r_mem[r_rd[c_aw-1:0]];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/iq_diff_slicer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : iq_diff_slicer                                            |
// | Differential-phase bit slicer, sync hunt and byte framer.          |
// | Option : IQ_DIFF_SLICER_ERASURE_EN adds the erasure output.        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module iq_diff_slicer
    import iq_demod_pkg::*;
#(
    parameter int          DATA_WIDTH  = c_data_width,
    parameter logic [15:0] SYNC_WORD   = c_sync_word_default,
    parameter int          FRAME_BYTES = 8,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] DOT_THRESH  = 32'h0000_1000
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         ce,
    input  wire logic                         strobe_in,
    input  wire logic signed [DATA_WIDTH+7:0] DI,
    input  wire logic signed [DATA_WIDTH+7:0] DQ,
    output logic                              bit_out,
    output logic                              bit_valid,
    output logic                              locked,
    output logic                              frame_start,
    output logic                              frame_done,
    iq_diff_slicer_if.master                  byte_if,
    output logic                              overflow
`ifdef IQ_DIFF_SLICER_ERASURE_EN
    , output logic                            erasure
`endif
);
    logic signed [c_v_w-1:0]   r_v_i, r_v_q, r_prev_i, r_prev_q;
    logic signed [c_p_w-1:0]   r_p_i, r_p_q;
    logic signed [c_dot_w-1:0] w_dot;
    logic                      r_cap_vld, r_p_vld, r_prev_ok;
    logic                      w_unused;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_sreg, w_sreg_nxt;
    logic [4:0]  r_hcnt, w_hcnt_nxt;
    logic [2:0]  r_bcnt, w_bcnt_nxt;
    logic [7:0]  r_byte_cnt, w_byte_cnt_nxt;
    logic [6:0]  r_shift, w_shift_nxt;
    logic [7:0]  w_din;
    logic        w_push, w_fs_nxt, w_fd_nxt;
    logic        w_empty, w_full, w_pop;
    logic [7:0]  w_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_vld <= 1'b0;
            r_v_i     <= '0;
            r_v_q     <= '0;
        end else begin
            r_cap_vld <= ce & strobe_in;
            if (ce & strobe_in) begin
                r_v_i <= DI[DATA_WIDTH+7 -: c_v_w];
                r_v_q <= DQ[DATA_WIDTH+7 -: c_v_w];
            end
        end
    end

    // The first vector after reset only seeds prev; no decision is made.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_vld   <= 1'b0;
            r_prev_ok <= 1'b0;
            r_prev_i  <= '0;
            r_prev_q  <= '0;
            r_p_i     <= '0;
            r_p_q     <= '0;
        end else begin
            r_p_vld <= r_cap_vld & r_prev_ok;
            if (r_cap_vld) begin
                r_p_i     <= r_v_i * r_prev_i;
                r_p_q     <= r_v_q * r_prev_q;
                r_prev_i  <= r_v_i;
                r_prev_q  <= r_v_q;
                r_prev_ok <= 1'b1;
            end
        end
    end

    assign w_dot = $signed({r_p_i[c_p_w-1], r_p_i}) + $signed({r_p_q[c_p_w-1], r_p_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
        end else begin
            bit_valid <= r_p_vld;
            if (r_p_vld) begin
                bit_out <= w_dot[c_dot_w-1];
            end
        end
    end

`ifdef IQ_DIFF_SLICER_ERASURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erasure <= 1'b0;
        end else begin
            erasure <= r_p_vld & (abs_dot(w_dot) < {1'b0, DOT_THRESH});
        end
    end
    assign w_unused = ^{DI[7:0], DQ[7:0]};
`else
    assign w_unused = ^{DI[7:0], DQ[7:0], DOT_THRESH};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_sreg_nxt     = r_sreg;
        w_hcnt_nxt     = r_hcnt;
        w_bcnt_nxt     = r_bcnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_shift_nxt    = r_shift;
        w_push         = 1'b0;
        w_fs_nxt       = 1'b0;
        w_fd_nxt       = 1'b0;
        w_din          = {r_shift, bit_out};
        case (r_state)
            HUNT: if (bit_valid) begin
                w_sreg_nxt = {r_sreg[14:0], bit_out};
                if (r_hcnt != 5'd16) begin
                    w_hcnt_nxt = r_hcnt + 5'd1;
                end
                if ((w_sreg_nxt == SYNC_WORD) && (w_hcnt_nxt == 5'd16)) begin
                    w_state_nxt    = DATA;
                    w_fs_nxt       = 1'b1;
                    w_bcnt_nxt     = '0;
                    w_byte_cnt_nxt = '0;
                end
            end
            DATA: if (bit_valid) begin
                w_shift_nxt = w_din[6:0];
                w_bcnt_nxt  = r_bcnt + 3'd1;
                if (r_bcnt == 3'd7) begin
                    w_push         = 1'b1;
                    w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                    if (r_byte_cnt == 8'(FRAME_BYTES - 1)) begin
                        w_fd_nxt    = 1'b1;
                        w_state_nxt = HUNT;
                        w_sreg_nxt  = '0;
                        w_hcnt_nxt  = '0;
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_sreg      <= '0;
            r_hcnt      <= '0;
            r_bcnt      <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_shift     <= w_shift_nxt;
            frame_start <= w_fs_nxt;
            frame_done  <= w_fd_nxt;
            overflow    <= overflow | (w_push & w_full & ~w_pop);
        end
    end

    assign locked = (r_state == DATA);
    assign w_pop  = ~w_empty & byte_if.byte_ready;

    iq_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign byte_if.byte_out   = w_dout;
    assign byte_if.byte_valid = ~w_empty;
endmodule
`default_nettype wire

// File: tb/tb_iq_diff_slicer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | Module : tb_iq_diff_slicer                                         |
// | Randomized scoreboard bench for iq_diff_slicer.                    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_iq_diff_slicer;
    localparam int          FRAME_BYTES = 8;
    localparam int          FIFO_DEPTH  = 4;
    localparam logic [15:0] SYNC        = 16'hA5C3;
    localparam longint      THRESH      = 64'h1000;

    logic        clk = 1'b0;
    logic        rst, ce, strobe_in;
    logic [23:0] DI, DQ;
    logic        bit_out, bit_valid, locked, frame_start, frame_done, overflow;
`ifdef IQ_DIFF_SLICER_ERASURE_EN
    logic        erasure;
`endif

    iq_diff_slicer_if u_if ();

    iq_diff_slicer #(
        .DATA_WIDTH  (16),
        .SYNC_WORD   (SYNC),
        .FRAME_BYTES (FRAME_BYTES),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DOT_THRESH  (32'h0000_1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .strobe_in   (strobe_in),
        .DI          (DI),
        .DQ          (DQ),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .locked      (locked),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .byte_if     (u_if.master),
        .overflow    (overflow)
`ifdef IQ_DIFF_SLICER_ERASURE_EN
        , .erasure   (erasure)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit er;
        bit fs;
        bit fd;
        bit lk;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_bytes[$];
    exp_t       pend;
    bit         pend_vld = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    // Reference model state: previous vector, recent hunt bits, payload bits.
    int  m_prev_i, m_prev_q;
    bit  m_prev_ok = 1'b0;
    bit  m_hist[$];
    bit  m_pay[$];
    bit  m_locked = 1'b0;
    int  m_nbytes = 0;
    bit  m_ovf = 1'b0;
    int  m_fill = 0;
    bit  ready_hold = 1'b0;
    bit  rnd_ready = 1'b0;
    int  amp = 12000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic void model_byte(input int v);
        if (ready_hold) begin
            if (m_fill >= FIFO_DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_fill++;
                exp_bytes.push_back(8'(v));
            end
        end else begin
            exp_bytes.push_back(8'(v));
        end
    endfunction

    function automatic void model_bit(input bit b, input bit er);
        exp_t e;
        int   w;
        e.b = b; e.er = er; e.fs = 1'b0; e.fd = 1'b0;
        if (!m_locked) begin
            m_hist.push_back(b);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
            w = 0;
            foreach (m_hist[i]) w = w * 2 + int'(m_hist[i]);
            if (m_hist.size() == 16 && w == int'(SYNC)) begin
                m_locked = 1'b1;
                e.fs     = 1'b1;
                m_pay.delete();
                m_nbytes = 0;
            end
        end else begin
            m_pay.push_back(b);
            if (m_pay.size() == 8) begin
                w = 0;
                foreach (m_pay[i]) w = w * 2 + int'(m_pay[i]);
                model_byte(w);
                m_pay.delete();
                m_nbytes++;
                if (m_nbytes == FRAME_BYTES) begin
                    e.fd     = 1'b1;
                    m_locked = 1'b0;
                    m_hist.delete();
                end
            end
        end
        e.lk = m_locked;
        exp_q.push_back(e);
    endfunction

    function automatic void model_capture(input int vi, input int vq);
        longint d;
        longint ad;
        if (m_prev_ok) begin
            d  = longint'(vi) * m_prev_i + longint'(vq) * m_prev_q;
            ad = (d < 0) ? -d : d;
            model_bit(d < 0, ad < THRESH);
        end
        m_prev_i  = vi;
        m_prev_q  = vq;
        m_prev_ok = 1'b1;
    endfunction

    task automatic step(input bit stb, input bit en, input logic [23:0] di, input logic [23:0] dq);
        int vi, vq;
        @(posedge clk);
        #1;
        strobe_in = stb;
        ce        = en;
        DI        = di;
        DQ        = dq;
        if (rnd_ready) u_if.byte_ready = 1'($urandom_range(0, 1));
        if (stb && en) begin
            vi = int'($signed(di[23:8]));
            vq = int'($signed(dq[23:8]));
            model_capture(vi, vq);
        end
    endtask

    task automatic gap();
        bit s;
        repeat ($urandom_range(0, 2)) begin
            s = 1'($urandom_range(0, 1));
            step(s, s ? 1'b0 : 1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom));
        end
    endtask

    task automatic send_bit(input bit b);
        int     vi, vq;
        longint d;
        vi = 1; vq = 1;
        for (int t = 0; t < 100; t++) begin
            vi = $urandom_range(0, 2 * amp) - amp;
            vq = $urandom_range(0, 2 * amp) - amp;
            d  = longint'(vi) * m_prev_i + longint'(vq) * m_prev_q;
            if (d != 0) begin
                if ((d < 0) != b) begin
                    vi = -vi;
                    vq = -vq;
                end
                break;
            end
        end
        step(1'b1, 1'b1, {vi[15:0], 8'($urandom)}, {vq[15:0], 8'($urandom)});
        gap();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic prime();
        step(1'b1, 1'b1, 24'h1F3A00, 24'hE21500);
    endtask

    task automatic send_frame(input bit seq_payload);
        send_byte(SYNC[15:8]);
        send_byte(SYNC[7:0]);
        for (int k = 0; k < FRAME_BYTES; k++) send_byte(seq_payload ? 8'(k) : 8'($urandom));
    endtask

    task automatic wait_idle();
        int t = 0;
        step(1'b0, 1'b1, 24'h0, 24'h0);
        while ((exp_q.size() != 0 || pend_vld) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("pipeline_drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic drain_bytes();
        int t = 0;
        while (exp_bytes.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("fifo_drain", 64'(exp_bytes.size()), 64'd0);
        chk("fifo_empty_valid", 64'(u_if.byte_valid), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_bit_out"}, 64'(bit_out), 64'd0);
        chk({tag, "_bit_valid"}, 64'(bit_valid), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_frame_start"}, 64'(frame_start), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_byte_out"}, 64'(u_if.byte_out), 64'd0);
        chk({tag, "_byte_valid"}, 64'(u_if.byte_valid), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
`ifdef IQ_DIFF_SLICER_ERASURE_EN
        chk({tag, "_erasure"}, 64'(erasure), 64'd0);
`endif
    endtask

    // Reset lands between clock edges to prove it does not wait for one.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst       = 1'b1;
        strobe_in = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        exp_q.delete();
        exp_bytes.delete();
        pend_vld  = 1'b0;
        m_prev_ok = 1'b0;
        m_hist.delete();
        m_pay.delete();
        m_locked  = 1'b0;
        m_ovf     = 1'b0;
        m_fill    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pend_vld) begin
                chk("frame_start", 64'(frame_start), 64'(pend.fs));
                chk("frame_done", 64'(frame_done), 64'(pend.fd));
                chk("locked", 64'(locked), 64'(pend.lk));
                pend_vld = 1'b0;
            end else if (frame_start || frame_done) begin
                chk("spurious_frame_event", 64'({frame_start, frame_done}), 64'd0);
            end
            if (bit_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit_valid", 64'd1, 64'd0);
                end else begin
                    pend = exp_q.pop_front();
                    chk("bit_out", 64'(bit_out), 64'(pend.b));
`ifdef IQ_DIFF_SLICER_ERASURE_EN
                    chk("erasure", 64'(erasure), 64'(pend.er));
`endif
                    pend_vld = 1'b1;
                end
            end
            if (u_if.byte_valid && u_if.byte_ready) begin
                if (exp_bytes.size() == 0) begin
                    chk("unexpected_byte", 64'(u_if.byte_out), 64'hFFFF);
                end else begin
                    chk("byte_out", 64'(u_if.byte_out), 64'(exp_bytes.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ce = 1'b0; strobe_in = 1'b0; DI = '0; DQ = '0;
        u_if.byte_ready = 1'b1;
        #12;
        check_outputs_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Constant vector: first strobe only seeds, next two decide 0 at latency 2.
        for (int s = 0; s < 3; s++) begin
            step(1'b1, 1'b1, 24'h010000, 24'h010000);
            repeat (3) step(1'b0, 1'b1, 24'h0, 24'h0);
            chk("latency_valid", 64'(bit_valid), (s == 0) ? 64'd0 : 64'd1);
        end
        wait_idle();

        // Sync and sequential payload, consumer always ready.
        prime();
        send_frame(1'b1);
        wait_idle();
        drain_bytes();
        chk("locked_after_frame", 64'(locked), 64'd0);
        chk("no_overflow", 64'(overflow), 64'd0);

        // Stalled consumer: four bytes stored, the rest dropped.
        u_if.byte_ready = 1'b0;
        ready_hold      = 1'b1;
        send_frame(1'b1);
        wait_idle();
        chk("overflow_sticky", 64'(overflow), 64'(m_ovf));
        chk("fifo_full_valid", 64'(u_if.byte_valid), 64'd1);
        chk("fifo_head", 64'(u_if.byte_out), 64'h00);
        ready_hold      = 1'b0;
        m_fill          = 0;
        u_if.byte_ready = 1'b1;
        drain_bytes();
        chk("overflow_holds", 64'(overflow), 64'd1);

        // Reset mid-frame with three bytes buffered.
        u_if.byte_ready = 1'b0;
        ready_hold      = 1'b1;
        send_byte(SYNC[15:8]);
        send_byte(SYNC[7:0]);
        for (int k = 0; k < 3; k++) send_byte(8'(k));
        repeat (5) step(1'b0, 1'b1, 24'h0, 24'h0);
        chk("pre_reset_buffered", 64'(u_if.byte_valid), 64'd1);
        chk("pre_reset_locked", 64'(locked), 64'd1);
        do_reset();
        ready_hold      = 1'b0;
        u_if.byte_ready = 1'b1;
        prime();
        send_byte(SYNC[7:0]);
        send_byte(8'h55);
        wait_idle();
        chk("partial_sync_no_lock", 64'(locked), 64'd0);
        send_frame(1'b0);
        wait_idle();
        drain_bytes();

        // Randomized frames with noise, stalls and mixed amplitudes.
        rnd_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            amp = (f % 2 == 0) ? 12000 : 60;
            repeat ($urandom_range(0, 10)) send_bit(1'($urandom_range(0, 1)));
            send_frame(1'b0);
        end
        amp = 12000;
        wait_idle();
        rnd_ready       = 1'b0;
        u_if.byte_ready = 1'b1;
        drain_bytes();

        // Low-confidence decisions: dot=2 and dot=512 erase, dot=0x20000 does not.
        do_reset();
        step(1'b1, 1'b1, 24'h000100, 24'h000100);
        step(1'b1, 1'b1, 24'h000100, 24'h000100);
        step(1'b1, 1'b1, 24'h010000, 24'h010000);
        step(1'b1, 1'b1, 24'h010000, 24'h010000);
        wait_idle();

        chk("final_bits_pending", 64'(exp_q.size()), 64'd0);
        chk("final_bytes_pending", 64'(exp_bytes.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
